// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding, the implicit ecall register index and RV32 instruction field positions.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } hazard_state_e;

  // ecall reads the syscall number from a7 (x17) without encoding it in rs1/rs2
  localparam logic [4:0] X17_IDX = 5'd17;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_hold;
  } hazard_ctrl_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard sources in, register controls out.
// The master side is the datapath; the slave side is the controller.
interface pipeline_hazard_ctrl_if;

  logic [31:0] id_inst;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_is_ecall;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic        ex_branch_taken;
  logic        id_halt;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_hold;
  logic        halted;
  logic [31:0] stall_count;

  modport master (
    output id_inst, id_uses_rs1, id_uses_rs2, id_is_ecall, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, id_halt, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, halted, stall_count
  );

  modport slave (
    input  id_inst, id_uses_rs1, id_uses_rs2, id_is_ecall, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, id_halt, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, halted, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that needs the result of a load
// still sitting in EX, including the implicit x17 read of ecall.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_is_ecall,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rd,
  output logic        load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic ecall_hit;

  assign rs1_hit   = id_uses_rs1 && (rs1_of(id_inst) == id_ex_rd);
  assign rs2_hit   = id_uses_rs2 && (rs2_of(id_inst) == id_ex_rd);
  assign ecall_hit = id_is_ecall && (id_ex_rd == X17_IDX);

  // x0 is hardwired zero, so a load into it never produces a value to wait for
  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) && (rs1_hit || rs2_hit || ecall_hit);

  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:0]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes, data
// memory wait holds and halt draining. Define HAZARD_PERF_EN for the stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  hazard_state_e state;
  logic [31:0]   drain_cnt;
  hazard_ctrl_t  ctrl;
  logic          load_use;
  logic          mem_stall;

  load_use_detect u_load_use_detect (
    .id_inst        (hz.id_inst),
    .id_uses_rs1    (hz.id_uses_rs1),
    .id_uses_rs2    (hz.id_uses_rs2),
    .id_is_ecall    (hz.id_is_ecall),
    .id_ex_mem_read (hz.id_ex_mem_read),
    .id_ex_rd       (hz.id_ex_rd),
    .load_use       (load_use)
  );

  assign mem_stall = hz.mem_req && !hz.mem_ready;

  // NOTE: state uses non-blocking assignments and an asynchronous reset so every
  // flop samples pre-edge values and reset takes effect without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state <= ST_MEM_WAIT;
          end else if (!hz.ex_branch_taken && !load_use && hz.id_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_CYCLES;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.mem_ready) state <= ST_RUN;
        end
        ST_DRAIN: begin
          if (hz.ex_branch_taken) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
          end else if (!mem_stall) begin
            // the cycle that would leave the counter at zero is the last drain cycle
            if (drain_cnt <= 32'd1) begin
              state     <= ST_HALTED;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt - 32'd1;
            end
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default: begin
          state     <= ST_RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // NOTE: every control gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl             = '0;
    ctrl.pc_write    = 1'b1;
    ctrl.if_id_write = 1'b1;
    case (state)
      ST_RUN: begin
        // a stalled MEM stage also freezes EX, so the branch cannot redirect yet
        if (mem_stall) begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.ex_mem_hold = 1'b1;
        end else if (hz.ex_branch_taken) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (load_use) begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_write = 1'b0;
        ctrl.ex_mem_hold = 1'b1;
      end
      ST_DRAIN: begin
        if (hz.ex_branch_taken) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
          ctrl.ex_mem_hold  = mem_stall;
        end
      end
      ST_HALTED: begin
        ctrl.pc_write     = 1'b0;
        ctrl.if_id_write  = 1'b0;
        ctrl.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.pc_write     = ctrl.pc_write;
  assign hz.if_id_write  = ctrl.if_id_write;
  assign hz.if_id_flush  = ctrl.if_id_flush;
  assign hz.id_ex_bubble = ctrl.id_ex_bubble;
  assign hz.ex_mem_hold  = ctrl.ex_mem_hold;
  assign hz.halted       = (state == ST_HALTED);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (!ctrl.pc_write && (state != ST_HALTED) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign hz.stall_count = stall_q;
`else
  assign hz.stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-level behavioural model
// checked every cycle, plus directed vectors with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 3;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] r_type(input int rs1, input int rs2, input int rd);
    logic [4:0] a, b, d;
    a = rs1[4:0];
    b = rs2[4:0];
    d = rd[4:0];
    return {7'b0, b, a, 3'b000, d, 7'b0110011};
  endfunction

  // ---------------- behavioural model ----------------
  // Pipeline situation as the rules describe it: waiting on memory, draining
  // with N cycles left (-1 when not draining), or halted for good.
  bit      m_wait   = 1'b0;
  int      m_drain  = -1;
  bit      m_halted = 1'b0;
  longint  m_stalls = 0;
  bit      n_wait   = 1'b0;
  int      n_drain  = -1;
  bit      n_halted = 1'b0;
  longint  n_stalls = 0;

  bit e_pc, e_ifw, e_flush, e_bub, e_hold;
  bit lu, ms;

  always @(negedge clk) begin
    lu = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
         ((hz.id_uses_rs1 && hz.id_inst[19:15] == hz.id_ex_rd) ||
          (hz.id_uses_rs2 && hz.id_inst[24:20] == hz.id_ex_rd) ||
          (hz.id_is_ecall && hz.id_ex_rd == 5'd17));
    ms = hz.mem_req && !hz.mem_ready;
    e_pc = 1; e_ifw = 1; e_flush = 0; e_bub = 0; e_hold = 0;
    n_wait = m_wait; n_drain = m_drain; n_halted = m_halted;
    if (m_halted) begin
      e_pc = 0; e_ifw = 0; e_bub = 1;
    end else if (m_wait) begin
      e_pc = 0; e_ifw = 0; e_hold = 1;
      if (hz.mem_ready) n_wait = 0;
    end else if (m_drain >= 0) begin
      if (hz.ex_branch_taken) begin
        e_flush = 1; e_bub = 1;
        n_drain = -1;
      end else begin
        e_pc = 0; e_ifw = 0; e_bub = 1; e_hold = ms;
        if (!ms) begin
          if (m_drain <= 1) begin n_drain = -1; n_halted = 1; end
          else n_drain = m_drain - 1;
        end
      end
    end else begin
      if (ms) begin
        e_pc = 0; e_ifw = 0; e_hold = 1; n_wait = 1;
      end else if (hz.ex_branch_taken) begin
        e_flush = 1; e_bub = 1;
      end else if (lu) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
      end else if (hz.id_halt) begin
        n_drain = DRAIN;
      end
    end
    n_stalls = m_stalls;
`ifdef HAZARD_PERF_EN
    if (!e_pc && !m_halted && m_stalls < 64'hFFFF_FFFF) n_stalls = m_stalls + 1;
`endif
    check("cmp_pc_write",     hz.pc_write,     e_pc);
    check("cmp_if_id_write",  hz.if_id_write,  e_ifw);
    check("cmp_if_id_flush",  hz.if_id_flush,  e_flush);
    check("cmp_id_ex_bubble", hz.id_ex_bubble, e_bub);
    check("cmp_ex_mem_hold",  hz.ex_mem_hold,  e_hold);
    check("cmp_halted",       hz.halted,       m_halted);
    check("cmp_stall_count",  hz.stall_count,  m_stalls[31:0]);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wait = 0; m_drain = -1; m_halted = 0; m_stalls = 0;
    end else begin
      m_wait = n_wait; m_drain = n_drain; m_halted = n_halted; m_stalls = n_stalls;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    hz.id_inst         = 32'h0000_0013;
    hz.id_uses_rs1     = 1'b0;
    hz.id_uses_rs2     = 1'b0;
    hz.id_is_ecall     = 1'b0;
    hz.id_ex_mem_read  = 1'b0;
    hz.id_ex_rd        = 5'd0;
    hz.ex_branch_taken = 1'b0;
    hz.id_halt         = 1'b0;
    hz.mem_req         = 1'b0;
    hz.mem_ready       = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // asserted just after a falling edge, released just after the next rising edge
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    clear_inputs();
    reset = 1'b0;
    #1;
    check("rst_async_pc_write", hz.pc_write, 1);
    check("rst_async_halted",   hz.halted,   0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic load_x5_add(input bit use_rs2_slot);
    hz.id_ex_mem_read = 1'b1;
    hz.id_ex_rd       = 5'd5;
    hz.id_inst        = use_rs2_slot ? r_type(7, 5, 6) : r_type(5, 7, 6);
    hz.id_uses_rs1    = 1'b1;
    hz.id_uses_rs2    = 1'b1;
  endtask

  task automatic halt_ecall();
    hz.id_inst     = ECALL;
    hz.id_is_ecall = 1'b1;
    hz.id_halt     = 1'b1;
  endtask

  int holds;

  initial begin
    clear_inputs();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    check("reset_pc_write",     hz.pc_write,     1);
    check("reset_if_id_write",  hz.if_id_write,  1);
    check("reset_if_id_flush",  hz.if_id_flush,  0);
    check("reset_id_ex_bubble", hz.id_ex_bubble, 0);
    check("reset_ex_mem_hold",  hz.ex_mem_hold,  0);
    check("reset_halted",       hz.halted,       0);
    check("reset_stall_count",  hz.stall_count,  0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_pc_write", hz.pc_write, 1);

    // lw x5 in EX, add x6,x5,x7 in ID: one stall cycle then normal
    next_cycle(); load_x5_add(1'b0);
    @(negedge clk);
    check("lu_rs1_pc_write",    hz.pc_write,     0);
    check("lu_rs1_if_id_write", hz.if_id_write,  0);
    check("lu_rs1_bubble",      hz.id_ex_bubble, 1);
    next_cycle(); hz.id_inst = r_type(5, 7, 6); hz.id_uses_rs1 = 1'b1; hz.id_uses_rs2 = 1'b1;
    @(negedge clk);
    check("lu_after_pc_write", hz.pc_write,     1);
    check("lu_after_bubble",   hz.id_ex_bubble, 0);

    // match through rs2, then same encoding with rs2 not read
    next_cycle(); load_x5_add(1'b1);
    @(negedge clk);
    check("lu_rs2_bubble", hz.id_ex_bubble, 1);
    next_cycle(); load_x5_add(1'b1); hz.id_uses_rs2 = 1'b0;
    @(negedge clk);
    check("lu_rs2_unused_pc_write", hz.pc_write, 1);

    // lw x17 with ecall in ID stalls; lw x0 never does
    next_cycle(); hz.id_ex_mem_read = 1'b1; hz.id_ex_rd = 5'd17; hz.id_inst = ECALL; hz.id_is_ecall = 1'b1;
    @(negedge clk);
    check("lu_ecall_pc_write", hz.pc_write, 0);
    next_cycle(); hz.id_ex_mem_read = 1'b1; hz.id_ex_rd = 5'd0; hz.id_inst = r_type(0, 0, 6);
    hz.id_uses_rs1 = 1'b1; hz.id_uses_rs2 = 1'b1;
    @(negedge clk);
    check("lu_x0_pc_write", hz.pc_write,     1);
    check("lu_x0_bubble",   hz.id_ex_bubble, 0);

    // taken branch overrides load-use
    next_cycle(); load_x5_add(1'b0); hz.ex_branch_taken = 1'b1;
    @(negedge clk);
    check("br_lu_flush",    hz.if_id_flush,  1);
    check("br_lu_bubble",   hz.id_ex_bubble, 1);
    check("br_lu_pc_write", hz.pc_write,     1);
    next_cycle();
    @(negedge clk);
    check("br_after_flush", hz.if_id_flush, 0);

    // memory wait: ready low 4 cycles, then high; counted from a fresh reset
    pulse_reset();
    holds = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      hz.mem_req   = 1'b1;
      hz.mem_ready = (i == 4);
      @(negedge clk);
      holds += int'(hz.ex_mem_hold);
    end
    check("mem_hold_cycles", holds, 5);
    next_cycle();
    @(negedge clk);
    check("mem_after_hold",     hz.ex_mem_hold, 0);
    check("mem_after_pc_write", hz.pc_write,    1);
`ifdef HAZARD_PERF_EN
    check("mem_stall_count", hz.stall_count, 5);
`else
    check("mem_stall_count", hz.stall_count, 0);
`endif

    // reset in the middle of a memory wait leaves no stall behind
    next_cycle(); hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    next_cycle(); hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    @(negedge clk);
    check("memwait_hold", hz.ex_mem_hold, 1);
    pulse_reset();
    @(negedge clk);
    check("memwait_rst_hold",     hz.ex_mem_hold, 0);
    check("memwait_rst_pc_write", hz.pc_write,    1);

    // halt with DRAIN_CYCLES=3: halted rises 4 cycles after the halt cycle
    next_cycle(); halt_ecall();
    @(negedge clk);
    check("halt_issue_pc_write", hz.pc_write, 1);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("drain_halted", hz.halted,       0);
      check("drain_bubble", hz.id_ex_bubble, 1);
    end
    for (int i = 4; i <= 6; i++) begin
      next_cycle();
      if (i == 5) hz.ex_branch_taken = 1'b1;
      @(negedge clk);
      check("halted_high",     hz.halted,   1);
      check("halted_pc_write", hz.pc_write, 0);
    end
    pulse_reset();

    // memory wait during drain freezes the countdown for two cycles
    next_cycle(); halt_ecall();
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      if (i <= 2) begin hz.mem_req = 1'b1; hz.mem_ready = 1'b0; end
      @(negedge clk);
      check("drain_freeze_halted", hz.halted, (i == 6) ? 32'd1 : 32'd0);
      if (i <= 2) check("drain_freeze_hold", hz.ex_mem_hold, 1);
    end
    pulse_reset();

    // taken branch during drain: ecall was on the wrong path
    next_cycle(); halt_ecall();
    next_cycle(); hz.ex_branch_taken = 1'b1;
    @(negedge clk);
    check("drain_br_flush",    hz.if_id_flush, 1);
    check("drain_br_pc_write", hz.pc_write,    1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      check("drain_br_resume_pc", hz.pc_write, 1);
      check("drain_br_halted",    hz.halted,   0);
    end

    // reset in the middle of a drain abandons it
    next_cycle(); halt_ecall();
    next_cycle();
    @(negedge clk);
    check("drain_mid_bubble", hz.id_ex_bubble, 1);
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      check("drain_rst_pc_write", hz.pc_write, 1);
      check("drain_rst_halted",   hz.halted,   0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles to drain EX/MEM/WB after a halt ecall leaves ID.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_inst  in  32  instruction in IF/ID.
REQ-005 SHALL have port id_uses_rs1 / id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-006 SHALL have port id_is_ecall  in  1  ID instruction is ecall, implicitly reading x17.
REQ-007 SHALL have port id_ex_mem_read / id_ex_rd  in  1 / 5  EX-stage load flag and destination.
REQ-008 SHALL have port ex_branch_taken  in  1  EX resolved a taken branch or jump (mispredict).
REQ-009 SHALL have port id_halt  in  1  ID ecall qualifies as halt (forwarded x17 == 10).
REQ-010 SHALL have port mem_req / mem_ready  in  1 / 1  MEM-stage access pending / data memory completes.
REQ-011 SHALL have ports pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold  out  1 each  pipeline register controls.
REQ-012 SHALL have port halted  out  1  pipeline fully drained after halt.
REQ-013 SHALL have port stall_count  out  32  stall-cycle counter (see Configuration).

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED, registered in clk domain.
REQ-015 Load-use hazard SHALL be: id_ex_mem_read, id_ex_rd != 0, and rd matches id_inst[19:15] with id_uses_rs1, or id_inst[24:20] with id_uses_rs2, or rd == 17 with id_is_ecall.
REQ-016 RUN, load-use, no taken branch: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; state stays RUN.
REQ-017 RUN, ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1; taken branch overrides simultaneous load-use.
REQ-018 RUN, mem_req && !mem_ready: next state MEM_WAIT; that cycle pc_write=0, if_id_write=0, ex_mem_hold=1.
REQ-019 MEM_WAIT: pc_write=0, if_id_write=0, ex_mem_hold=1, no flush or bubble; exit to RUN on cycle mem_ready=1, which itself still holds.
REQ-020 RUN, id_halt with no load-use and no taken branch: halt ecall advances; next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-021 DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1; counter decrements per cycle; mem_req && !mem_ready freezes counter and asserts ex_mem_hold; at 0 go HALTED.
REQ-022 DRAIN, ex_branch_taken (ecall on wrong path): if_id_flush=1, return to RUN, counter cleared.
REQ-023 HALTED: halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1; terminal until reset.
REQ-024 All other RUN cycles: pc_write=1, if_id_write=1, other controls 0.
REQ-025 Control outputs SHALL be combinational from state and inputs; only state, drain counter and stall_count are registered.

Reset
REQ-026 Reset low SHALL asynchronously force RUN, drain counter 0, stall_count 0, halted 0.
REQ-027 During and after reset, before any input event, outputs SHALL be pc_write=1, if_id_write=1, others 0.
REQ-028 Reset asserted mid-DRAIN or MEM_WAIT SHALL abandon the operation without a residual stall.

Configuration
REQ-029 With HAZARD_PERF_EN defined, stall_count SHALL increment every cycle pc_write=0 and state != HALTED, saturating at 32'hFFFFFFFF.
REQ-030 Without HAZARD_PERF_EN, stall_count SHALL be constant 0 with no counter flops.

Structure
REQ-031 Shared package SHALL hold the state enum, x17 index constant (5'd17) and opcode field slice positions.
REQ-032 Load-use comparator SHALL be sub-module load_use_detect; FSM and counters stay in top.

Verification
REQ-033 lw x5 in EX, add using x5 in ID -> one cycle pc_write=0, id_ex_bubble=1, then normal.
REQ-034 lw x17 in EX, ecall in ID -> one-cycle stall; lw x0 in EX -> no stall.
REQ-035 Load-use and ex_branch_taken same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1.
REQ-036 mem_req=1, mem_ready low 4 cycles -> ex_mem_hold=1 for 5 cycles, back in RUN after; stall_count=5 with HAZARD_PERF_EN.
REQ-037 id_halt, DRAIN_CYCLES=3, no memory wait -> halted rises 4 cycles later, stays high; reset low -> halted=0 immediately.
